paddle_ctrl: RTL and testbench

- Upstream neighbour of the ball block: turns one player's up/down push-buttons into the four paddle plane coordinates (leftPlane, rightPlane, topPlane, bottomPlane) that ball collision logic consumes.
- Also produces drawPaddle for the top-level pixel mux.
- Instantiated twice in PongGame, once for the left paddle and once for the right; each runs on pixelClock.

---
 rtl/pong_pkg.sv | 16 +
 rtl/paddle_ctrl_if.sv | 23 ++
 rtl/paddle_ctrl_btn_debounce.sv | 45 ++++
 rtl/paddle_ctrl.sv | 157 +++++++++++++++
 tb/tb_paddle_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared Pong types and screen geometry used by the paddle and ball blocks.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        BLOCKED = 2'd3
    } paddle_state_t;

    typedef logic [10:0] coord_t;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Video-side bundle of a paddle: pixel position in, collision planes and draw flag out.
interface paddle_ctrl_if;
    import pong_pkg::*;

    logic [10:0] xPosition;
    logic [9:0]  yPosition;
    coord_t      leftPlane;
    coord_t      rightPlane;
    coord_t      topPlane;
    coord_t      bottomPlane;
    logic        drawPaddle;

    modport master (
        input  xPosition, yPosition,
        output leftPlane, rightPlane, topPlane, bottomPlane, drawPaddle
    );

    modport slave (
        output xPosition, yPosition,
        input  leftPlane, rightPlane, topPlane, bottomPlane, drawPaddle
    );

endinterface

// File: rtl/paddle_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw push-button.
module btn_debounce #(
    parameter int debounceCycles = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(debounceCycles);
    localparam logic [CW-1:0] CNT_LAST = CW'(debounceCycles - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A mismatch must persist for debounceCycles consecutive cycles to be accepted.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/paddle_ctrl.sv
// One player's paddle: debounced buttons drive a move FSM that steps paddleY on a prescaled tick.
// Optional CPU tracking of the ball is enabled by defining PADDLE_AUTO_EN.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int pLeft          = 10,
    parameter int pTop           = 250,
    parameter int pWidth         = 10,
    parameter int pHeight        = 100,
    parameter int screenHeight   = 600,
    parameter int stepPix        = 2,
    parameter int moveDiv        = 100000,
    parameter int debounceCycles = 250000
) (
    input  logic           pixelClock,
    input  logic           nReset,
    input  logic           btnUp,
    input  logic           btnDown,
    input  logic           autoMode,
    input  logic [9:0]     ballCentreY,
    paddle_ctrl_if.master  vid,
    output logic           moving
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_UP      = UP;
    localparam logic [1:0] S_DOWN    = DOWN;
    localparam logic [1:0] S_BLOCKED = BLOCKED;

    localparam int PW = $clog2(moveDiv);
    localparam logic [PW-1:0] PRE_LAST = PW'(moveDiv - 1);

    localparam logic [11:0] STEP12 = 12'(stepPix);
    localparam logic [11:0] H12    = 12'(pHeight);
    localparam logic [11:0] SH12   = 12'(screenHeight);

    logic          up_db, dn_db;
    logic [PW-1:0] pre_q, pre_d;
    logic          moveTick;
    logic [1:0]    state_q, state_d, fsm_next;
    coord_t        paddleY_q, paddleY_d;
    coord_t        up_y, dn_y;
    logic [11:0]   y12;
    logic          fsm_moving;

    btn_debounce #(.debounceCycles(debounceCycles)) u_db_up (
        .clk_i   (pixelClock),
        .rst_ni  (nReset),
        .btn_i   (btnUp),
        .level_o (up_db)
    );

    btn_debounce #(.debounceCycles(debounceCycles)) u_db_dn (
        .clk_i   (pixelClock),
        .rst_ni  (nReset),
        .btn_i   (btnDown),
        .level_o (dn_db)
    );

    assign moveTick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = moveTick ? '0 : pre_q + 1'b1;
    end

    always_comb begin
        fsm_next = state_q;
        case (state_q)
            S_IDLE: begin
                if (up_db && dn_db)  fsm_next = S_BLOCKED;
                else if (up_db)      fsm_next = S_UP;
                else if (dn_db)      fsm_next = S_DOWN;
            end
            S_UP: begin
                if (up_db && dn_db)  fsm_next = S_BLOCKED;
                else if (!up_db)     fsm_next = S_IDLE;
            end
            S_DOWN: begin
                if (up_db && dn_db)  fsm_next = S_BLOCKED;
                else if (!dn_db)     fsm_next = S_IDLE;
            end
            default: begin
                if (!up_db && !dn_db) fsm_next = S_IDLE;
            end
        endcase
    end

    // Clamp tests run in 12 bits so paddleY+pHeight+stepPix cannot wrap.
    assign y12  = {1'b0, paddleY_q};
    assign up_y = (y12 < STEP12) ? '0 : paddleY_q - 11'(stepPix);
    assign dn_y = (y12 + H12 + STEP12 > SH12) ? 11'(screenHeight - pHeight)
                                               : paddleY_q + 11'(stepPix);

    assign fsm_moving = (state_q == S_UP) || (state_q == S_DOWN);

`ifdef PADDLE_AUTO_EN
    logic [11:0] centre12, ball12;
    coord_t      auto_y;

    assign centre12 = y12 + 12'(pHeight / 2);
    assign ball12   = {2'b00, ballCentreY};

    always_comb begin
        auto_y = paddleY_q;
        if (centre12 >= ball12 + STEP12)      auto_y = up_y;
        else if (centre12 + STEP12 <= ball12) auto_y = dn_y;
    end

    always_comb begin
        state_d   = autoMode ? S_IDLE : fsm_next;
        paddleY_d = paddleY_q;
        if (moveTick) begin
            if (autoMode)                paddleY_d = auto_y;
            else if (state_q == S_UP)    paddleY_d = up_y;
            else if (state_q == S_DOWN)  paddleY_d = dn_y;
        end
    end

    assign moving = autoMode ? (moveTick && (auto_y != paddleY_q)) : fsm_moving;
`else
    logic unused_auto;
    assign unused_auto = ^{autoMode, ballCentreY};

    always_comb begin
        state_d   = fsm_next;
        paddleY_d = paddleY_q;
        if (moveTick) begin
            if (state_q == S_UP)        paddleY_d = up_y;
            else if (state_q == S_DOWN) paddleY_d = dn_y;
        end
    end

    assign moving = fsm_moving;
`endif

    always_ff @(posedge pixelClock or negedge nReset) begin
        if (!nReset) begin
            pre_q     <= '0;
            state_q   <= S_IDLE;
            paddleY_q <= 11'(pTop);
        end else begin
            pre_q     <= pre_d;
            state_q   <= state_d;
            paddleY_q <= paddleY_d;
        end
    end

    assign vid.leftPlane   = 11'(pLeft);
    assign vid.rightPlane  = 11'(pLeft + pWidth);
    assign vid.topPlane    = paddleY_q;
    assign vid.bottomPlane = paddleY_q + 11'(pHeight);
    assign vid.drawPaddle  = (vid.xPosition > vid.leftPlane) &&
                             (vid.xPosition < vid.rightPlane) &&
                             ({1'b0, vid.yPosition} > vid.topPlane) &&
                             ({1'b0, vid.yPosition} < vid.bottomPlane);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomized bench for paddle_ctrl against a behavioural paddle model (button-only build).
module tb_paddle_ctrl;

    localparam int P_LEFT   = 10;
    localparam int P_TOP    = 250;
    localparam int P_WIDTH  = 10;
    localparam int P_HEIGHT = 100;
    localparam int SCR_H    = 600;
    localparam int STEP     = 2;
    localparam int MDIV     = 4;
    localparam int DEB      = 3;

    logic       clk = 1'b0;
    logic       nReset;
    logic       btnUp, btnDown;
    logic       autoMode;
    logic [9:0] ballCentreY;
    logic       moving;

    int checks = 0;
    int errors = 0;

    paddle_ctrl_if vif ();

    paddle_ctrl #(
        .pLeft(P_LEFT), .pTop(P_TOP), .pWidth(P_WIDTH), .pHeight(P_HEIGHT),
        .screenHeight(SCR_H), .stepPix(STEP), .moveDiv(MDIV), .debounceCycles(DEB)
    ) dut (
        .pixelClock  (clk),
        .nReset      (nReset),
        .btnUp       (btnUp),
        .btnDown     (btnDown),
        .autoMode    (autoMode),
        .ballCentreY (ballCentreY),
        .vid         (vif),
        .moving      (moving)
    );

    always #5 clk = ~clk;

    // Model: position, press direction, accepted button levels and their raw history.
    int m_y;
    int m_dir;          // 0 none, 1 up, 2 down, 3 both-held lockout
    int m_cyc;
    bit m_lvl [2];
    int m_run [2];
    bit m_hist[2][$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_y   = P_TOP;
        m_dir = 0;
        m_cyc = 0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 1'b0;
            m_run[b] = 0;
            m_hist[b].delete();
        end
    endfunction

    // One rising edge: raw buttons reach the debouncer two edges late and are
    // accepted after DEB consecutive differing cycles; movement uses the old direction.
    function automatic void model_edge(input bit up, input bit dn);
        bit raw [2];
        bit seen[2];
        bit lu, ld;
        int nd;
        raw[0] = up;
        raw[1] = dn;
        lu = m_lvl[0];
        ld = m_lvl[1];
        if ((m_cyc % MDIV) == MDIV - 1) begin
            if (m_dir == 1) m_y = (m_y - STEP < 0) ? 0 : m_y - STEP;
            if (m_dir == 2) m_y = (m_y + P_HEIGHT + STEP > SCR_H) ? SCR_H - P_HEIGHT : m_y + STEP;
        end
        nd = m_dir;
        if (lu && ld)            nd = 3;
        else if (m_dir == 3)     nd = 3;
        else if (m_dir == 1)     nd = lu ? 1 : 0;
        else if (m_dir == 2)     nd = ld ? 2 : 0;
        else                     nd = lu ? 1 : (ld ? 2 : 0);
        if (m_dir == 3 && !lu && !ld) nd = 0;
        m_dir = nd;
        for (int b = 0; b < 2; b++) begin
            seen[b] = (m_hist[b].size() == 2) ? m_hist[b][0] : 1'b0;
            m_hist[b].push_back(raw[b]);
            if (m_hist[b].size() > 2) void'(m_hist[b].pop_front());
            if (seen[b] == m_lvl[b]) m_run[b] = 0;
            else begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = seen[b];
                    m_run[b] = 0;
                end
            end
        end
        m_cyc++;
    endfunction

    function automatic bit model_draw(input int x, input int y);
        return (x > P_LEFT) && (x < P_LEFT + P_WIDTH) && (y > m_y) && (y < m_y + P_HEIGHT);
    endfunction

    task automatic check_planes();
        chk("topPlane", int'(vif.topPlane), m_y);
        chk("bottomPlane", int'(vif.bottomPlane), m_y + P_HEIGHT);
        chk("moving", int'(moving), (m_dir == 1 || m_dir == 2) ? 1 : 0);
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input bit up, input bit dn);
        int x, y;
        btnUp   = up;
        btnDown = dn;
        x = $urandom_range(5, 25);
        case ($urandom_range(0, 2))
            0: y = m_y + $urandom_range(0, 4) - 2;
            1: y = m_y + P_HEIGHT + $urandom_range(0, 4) - 2;
            default: y = $urandom_range(0, 599);
        endcase
        if (y < 0) y = 0;
        vif.xPosition = 11'(x);
        vif.yPosition = 10'(y);
        #1;
        chk("drawPaddle", int'(vif.drawPaddle), int'(model_draw(x, y)));
        @(posedge clk);
        model_edge(up, dn);
        @(negedge clk);
        check_planes();
    endtask

    task automatic hold(input bit up, input bit dn, input int n);
        for (int i = 0; i < n; i++) cycle(up, dn);
    endtask

    task automatic reset_pulse();
        #2 nReset = 1'b0;
        #1;
        chk("rst_top", int'(vif.topPlane), P_TOP);
        chk("rst_moving", int'(moving), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        nReset = 1'b1;
    endtask

    initial begin
        nReset        = 1'b0;
        btnUp         = 1'b0;
        btnDown       = 1'b0;
        autoMode      = 1'b0;
        ballCentreY   = 10'd0;
        vif.xPosition = '0;
        vif.yPosition = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_top", int'(vif.topPlane), P_TOP);
        chk("rst_bottom", int'(vif.bottomPlane), P_TOP + P_HEIGHT);
        chk("leftPlane", int'(vif.leftPlane), P_LEFT);
        chk("rightPlane", int'(vif.rightPlane), P_LEFT + P_WIDTH);
        chk("rst_moving", int'(moving), 0);
        nReset = 1'b1;

        hold(0, 0, 20);
        hold(1, 0, 40);
        hold(0, 0, 10);
        // Run into both clamps and sit on them.
        hold(1, 0, 600);
        chk("clamp_top", int'(vif.topPlane), 0);
        hold(0, 0, 8);
        hold(0, 1, 1100);
        chk("clamp_bottom", int'(vif.bottomPlane), SCR_H);
        hold(0, 0, 8);
        // Both held, then partial release, then full release.
        hold(1, 0, 10);
        hold(1, 1, 20);
        hold(0, 1, 20);
        hold(0, 0, 12);
        // Short glitches are ignored.
        hold(0, 1, 2);
        hold(0, 0, 8);
        hold(1, 0, 1);
        hold(0, 0, 8);
        // Reset during a downward move.
        hold(1, 0, 60);
        hold(0, 1, 30);
        reset_pulse();
        hold(0, 0, 6);

        for (int s = 0; s < 120; s++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 3);
            len  = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 80) : $urandom_range(1, 8);
            hold(kind[0], kind[1], len);
            if ($urandom_range(0, 40) == 0) begin
                reset_pulse();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
